// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial sequence detector with overlapping/non-overlapping modes.
// Optional saturating match counter is built when MATCH_COUNT_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// 0         | S(0): no prefix of PATTERN matched yet
// 1..LEN-1  | S(k): last k bits received equal the first k pattern bits
// LEN       | S(LEN): full pattern received, y = 1
// > LEN     | illegal encoding, recovers to S(0) on the next edge
module moore_seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = $clog2(PAT_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          x,
  output logic          y,
  output logic [SW-1:0] state
`ifdef MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  typedef logic [SW-1:0] state_t;

  localparam int     N_ENC   = 1 << SW;
  localparam state_t S_IDLE  = '0;
  localparam state_t S_MATCH = state_t'(PAT_LEN);

  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pat_bit(input int i);
    return 1'(PATTERN >> (PAT_LEN - 1 - i));
  endfunction

  // Longest pattern prefix that is a suffix of prefix(k) followed by b.
  function automatic state_t next_k(input int k_in, input logic b);
    logic [31:0] seq;
    int          k;
    int          len;
    int          best;
    logic        ok;
    if (k_in > PAT_LEN) return S_IDLE;
    k = (k_in == PAT_LEN && !OVERLAP) ? 0 : k_in;
    seq = '0;
    for (int i = 0; i < k; i++) seq = seq | (32'(pat_bit(i)) << i);
    seq  = seq | (32'(b) << k);
    len  = k + 1;
    best = 0;
    for (int j = 1; j <= PAT_LEN; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          if (1'(seq >> (len - j + t)) != pat_bit(t)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return state_t'(best);
  endfunction

  // Transition table sized to every encoding so any state value indexes safely.
  state_t tab0 [N_ENC];
  state_t tab1 [N_ENC];

  for (genvar k = 0; k < N_ENC; k++) begin : g_tab
    localparam state_t NXT0 = next_k(k, 1'b0);
    localparam state_t NXT1 = next_k(k, 1'b1);
    assign tab0[k] = NXT0;
    assign tab1[k] = NXT1;
  end

  state_t state_q;
  state_t state_nxt;
  state_t step_nxt;
  logic   illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    step_nxt  = x ? tab1[state_q] : tab0[state_q];
    illegal   = (state_q > S_MATCH);
    state_nxt = state_q;
    if (clr)          state_nxt = S_IDLE;
    else if (illegal) state_nxt = S_IDLE;
    else if (en)      state_nxt = step_nxt;
  end

  assign y     = (state_q == S_MATCH);
  assign state = state_q;

`ifdef MATCH_COUNT_EN
  logic cnt_inc;

  // Counts on every enabled edge that lands in the match state.
  assign cnt_inc = en && !clr && !illegal && (step_nxt == S_MATCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            match_cnt <= '0;
    else if (clr)                        match_cnt <= '0;
    else if (cnt_inc && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: directed scenarios plus randomized traffic
// checked against a bit-history model; covers match_cnt when MATCH_COUNT_EN is set.
module tb_moore_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic x   = 1'b0;

  always #5 clk = ~clk;

  logic       y_o  [4];
  logic [2:0] st_o [4];
`ifdef MATCH_COUNT_EN
  logic [7:0] cnt_o [4];
  logic [1:0] cnt2;
  assign cnt_o[2] = {6'd0, cnt2};
`endif

  moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y_o[0]), .state(st_o[0])
`ifdef MATCH_COUNT_EN
    , .match_cnt(cnt_o[0])
`endif
  );

  moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y_o[1]), .state(st_o[1])
`ifdef MATCH_COUNT_EN
    , .match_cnt(cnt_o[1])
`endif
  );

  moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y_o[2]), .state(st_o[2])
`ifdef MATCH_COUNT_EN
    , .match_cnt(cnt2)
`endif
  );

  moore_seq_detector #(.PAT_LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(8)) u_p6 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y_o[3]), .state(st_o[3])
`ifdef MATCH_COUNT_EN
    , .match_cnt(cnt_o[3])
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          plen [4] = '{4, 4, 4, 6};
  int          ovl  [4] = '{1, 0, 1, 1};
  int          cmax [4] = '{255, 255, 3, 255};
  logic [15:0] patv [4] = '{16'b1011, 16'b1011, 16'b1011, 16'b110110};

  bit hist    [4][$];
  int exp_st  [4];
  int exp_cnt [4];

  // Longest pattern prefix that ends the received history.
  function automatic int longest(input int i);
    int n;
    int best;
    bit ok;
    n    = hist[i].size();
    best = 0;
    for (int j = 1; j <= plen[i] && j <= n; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++)
        if (hist[i][n - j + t] != 1'(patv[i] >> (plen[i] - 1 - t))) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      exp_st[i]  = 0;
      exp_cnt[i] = 0;
    end
  endtask

  task automatic step(input logic e, input logic c, input logic b);
    @(negedge clk);
    en  = e;
    clr = c;
    x   = b;
    @(posedge clk);
    if (c) model_reset();
    else if (e) begin
      for (int i = 0; i < 4; i++) begin
        // Non-overlapping: a completed match forgets all earlier bits.
        if (ovl[i] == 0 && exp_st[i] == plen[i]) hist[i].delete();
        hist[i].push_back(b);
        while (hist[i].size() > plen[i]) void'(hist[i].pop_front());
        exp_st[i] = longest(i);
        if (exp_st[i] == plen[i] && exp_cnt[i] < cmax[i]) exp_cnt[i]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (st_o[i] !== 3'd0 || y_o[i] !== 1'b0)
        $display("FAIL reset inst%0d: state=%0d y=%0b, expected state=0 y=0", i, st_o[i], y_o[i]);
      else n_pass++;
`ifdef MATCH_COUNT_EN
      n_checks++;
      if (cnt_o[i] !== 8'd0)
        $display("FAIL reset_cnt inst%0d: got %0d expected 0", i, cnt_o[i]);
      else n_pass++;
`endif
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   exp0 [4] = '{1, 2, 3, 4};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, bits[k]);
      n_checks++;
      if (st_o[0] !== 3'(exp0[k]) || y_o[0] !== (k == 3))
        $display("FAIL basic bit%0d: state=%0d y=%0b, expected state=%0d y=%0b",
                 k, st_o[0], y_o[0], exp0[k], (k == 3));
      else n_pass++;
      n_checks++;
      if (st_o[3] !== 3'(exp_st[3]))
        $display("FAIL basic_p6 bit%0d: got %0d expected %0d", k, st_o[3], exp_st[3]);
      else n_pass++;
    end
  endtask

  task automatic test_overlap();
    logic bits [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic ov_y [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic no_y [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 11; k++) begin
      step(1'b1, 1'b0, bits[k]);
      n_checks++;
      if (y_o[0] !== ov_y[k])
        $display("FAIL overlap_y bit%0d: got %0b expected %0b", k, y_o[0], ov_y[k]);
      else n_pass++;
      n_checks++;
      if (y_o[1] !== no_y[k])
        $display("FAIL nonoverlap_y bit%0d: got %0b expected %0b", k, y_o[1], no_y[k]);
      else n_pass++;
`ifdef MATCH_COUNT_EN
      if (k == 6) begin
        n_checks++;
        if (cnt_o[0] !== 8'd2)
          $display("FAIL overlap_cnt: got %0d expected 2", cnt_o[0]);
        else n_pass++;
      end
`endif
    end
`ifdef MATCH_COUNT_EN
    n_checks++;
    if (cnt_o[1] !== 8'd2)
      $display("FAIL nonoverlap_cnt: got %0d expected 2", cnt_o[1]);
    else n_pass++;
`endif
  endtask

  task automatic test_enable();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      n_checks++;
      if (st_o[0] !== 3'd2 || y_o[0] !== 1'b0)
        $display("FAIL enable_hold cyc%0d: state=%0d y=%0b, expected state=2 y=0", k, st_o[0], y_o[0]);
      else n_pass++;
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st_o[0] !== 3'd2 || y_o[0] !== 1'b0)
      $display("FAIL enable_fallback: state=%0d y=%0b, expected state=2 y=0", st_o[0], y_o[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (st_o[i] !== 3'd0 || y_o[i] !== 1'b0)
        $display("FAIL async_reset inst%0d: state=%0d y=%0b, expected 0/0", i, st_o[i], y_o[i]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (st_o[0] !== 3'd0 || y_o[0] !== 1'b0)
      $display("FAIL clr_on_final: state=%0d y=%0b, expected 0/0", st_o[0], y_o[0]);
    else n_pass++;
`ifdef MATCH_COUNT_EN
    n_checks++;
    if (cnt_o[0] !== 8'd0)
      $display("FAIL clr_cnt: got %0d expected 0", cnt_o[0]);
    else n_pass++;
`endif
  endtask

  task automatic test_saturation();
    logic bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b1, 1'b1, 1'b0);
    for (int m = 1; m <= 5; m++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, bits[k]);
      n_checks++;
      if (y_o[2] !== 1'b1)
        $display("FAIL b2b_y match%0d: got %0b expected 1", m, y_o[2]);
      else n_pass++;
`ifdef MATCH_COUNT_EN
      n_checks++;
      if (cnt2 !== 2'((m < 3) ? m : 3))
        $display("FAIL sat_cnt match%0d: got %0d expected %0d", m, cnt2, (m < 3) ? m : 3);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_random();
    logic e;
    logic c;
    logic b;
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 600; n++) begin
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 31) == 0);
      b = 1'($urandom_range(0, 1));
      step(e, c, b);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (st_o[i] !== 3'(exp_st[i]) || y_o[i] !== (exp_st[i] == plen[i]))
          $display("FAIL random cyc%0d inst%0d: state=%0d y=%0b, expected state=%0d y=%0b",
                   n, i, st_o[i], y_o[i], exp_st[i], (exp_st[i] == plen[i]));
        else n_pass++;
`ifdef MATCH_COUNT_EN
        n_checks++;
        if (cnt_o[i] !== 8'(exp_cnt[i]))
          $display("FAIL random_cnt cyc%0d inst%0d: got %0d expected %0d", n, i, cnt_o[i], exp_cnt[i]);
        else n_pass++;
`endif
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overlap();
    test_enable();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
